hermes_input_buffer: RTL

Per-port input stage of the Hermes router, directly upstream of the crossbar. It accepts flits from the incoming link under credit flow control and stores them in a circular FIFO. It raises a routing request to switch control when a header reaches the FIFO head. After the grant, it presents flits to the crossbar (data_av/data/ack) and tracks packet length to tell switch control when the packet is done.

---
 rtl/hermes_input_buffer_pkg.sv | 13 +
 rtl/hermes_input_buffer_fifo.sv | 58 +++++
 rtl/hermes_input_buffer.sv | 79 +++++++
 3 files changed

// File: rtl/hermes_input_buffer_pkg.sv
// Shared types for the Hermes router input stage.
//   hermes_ibuf_state_t : input-buffer packet FSM states
package hermes_input_buffer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD
  } hermes_ibuf_state_t;

endpackage

// File: rtl/hermes_input_buffer_fifo.sv
// Circular flit FIFO for the Hermes input buffer.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_wr, i_data     : write strobe and flit (refused when full)
//   i_rd             : pop the head flit (ignored when empty)
//   o_data           : head flit, combinational from registered state
//   o_full, o_empty  : occupancy flags
module hermes_fifo #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [FLIT_SIZE-1:0] i_data,
  input  logic                 i_rd,
  output logic [FLIT_SIZE-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int PW = $clog2(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] r_mem [BUFFER_SIZE];
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 w_wr, w_rd;

  assign o_full  = (r_count == CW'(BUFFER_SIZE));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr && !o_full;
  assign w_rd    = i_rd && !o_empty;
  assign o_data  = r_mem[r_rptr];

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  // BUFFER_SIZE is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes router per-port input stage.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   rx_i, data_i, credit_o: incoming link, credit flow control
//   h_o, ack_h_i          : routing request / grant with switch control
//   data_av_o, data_o,
//   data_ack_i            : head flit toward the crossbar and its consume strobe
//   sender_o              : packet in progress (falls when the packet is done)
module hermes_input_buffer
  import hermes_input_buffer_pkg::*;
#(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 h_o,
  input  logic                 ack_h_i,
  output logic                 data_av_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 data_ack_i,
  output logic                 sender_o
);

  hermes_ibuf_state_t   r_state;
  logic [FLIT_SIZE-1:0] r_remaining;
  logic                 w_full, w_empty, w_wr, w_rd, w_xfer_state;

  assign credit_o     = !rst_i && !w_full;
  assign w_wr         = rx_i && credit_o;
  assign w_xfer_state = (r_state == S_HEADER) || (r_state == S_SIZE) ||
                        (r_state == S_PAYLOAD);
  assign data_av_o    = !rst_i && w_xfer_state && !w_empty;
  assign w_rd         = data_av_o && data_ack_i;
  assign h_o          = !rst_i && (r_state == S_REQ);
  assign sender_o     = !rst_i && (r_state != S_IDLE);

  hermes_fifo #(
    .FLIT_SIZE  (FLIT_SIZE),
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_fifo (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_wr   (w_wr),
    .i_data (data_i),
    .i_rd   (w_rd),
    .o_data (data_o),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // Flit order within a packet: header, size (payload count), payload...
  // Every transition out of a transfer state is gated by an actual read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE:    if (!w_empty) r_state <= S_REQ;
        S_REQ:     if (ack_h_i)  r_state <= S_HEADER;
        S_HEADER:  if (w_rd)     r_state <= S_SIZE;
        S_SIZE: if (w_rd) begin
          r_remaining <= data_o;
          r_state     <= (data_o == '0) ? S_IDLE : S_PAYLOAD;
        end
        S_PAYLOAD: if (w_rd) begin
          r_remaining <= r_remaining - FLIT_SIZE'(1);
          if (r_remaining == FLIT_SIZE'(1)) r_state <= S_IDLE;
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
